// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: walks the PC over a byte-wide instruction memory,
// assembles little-endian 32-bit words and hands them to decode over valid/ready.
// Handles execute redirects, halt on ecall, and sticky fetch faults.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 44
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [32:0] MEM_LIMIT     = 33'(MEM_BYTES);
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic [7:0]  lane0;
    logic [7:0]  lane1;
    logic [7:0]  lane2;

    logic [1:0]  cnt_inc_c;
    logic        range_bad_c;
    logic        redirect_misaligned_c;

    // Next byte index, and the range check done in 33 bits so pc+4 cannot wrap past it
    assign cnt_inc_c             = cnt + 2'd1;
    assign range_bad_c           = ({1'b0, pc} + 33'd4) > MEM_LIMIT;
    assign redirect_misaligned_c = (redirect_pc[1:0] != 2'b00);

    // Fetch FSM; imem_addr is kept registered and always tracks pc (+cnt while fetching)
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            cnt         <= 2'd0;
            lane0       <= 8'h00;
            lane1       <= 8'h00;
            lane2       <= 8'h00;
            imem_addr   <= RESET_PC;
            inst_out    <= 32'h0;
            inst_pc     <= RESET_PC;
            inst_valid  <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            case (state)
                FETCH: begin
                    if (halt) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        imem_addr <= pc;
                    end else if (redirect_valid) begin
                        pc        <= redirect_pc;
                        cnt       <= 2'd0;
                        imem_addr <= redirect_pc;
                        if (redirect_misaligned_c) begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                        end
                    end else if ((cnt == 2'd0) && range_bad_c) begin
                        state       <= FAULT;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_RANGE;
                    end else begin
                        case (cnt)
                            2'd0: lane0 <= imem_rdata;
                            2'd1: lane1 <= imem_rdata;
                            2'd2: lane2 <= imem_rdata;
                            2'd3: begin
                                inst_out   <= {imem_rdata, lane2, lane1, lane0};
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                state      <= VALID;
                            end
                            default: ;
                        endcase
                        cnt       <= cnt_inc_c;
                        imem_addr <= pc + 32'(cnt_inc_c);
                    end
                end

                VALID: begin
                    if (halt) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        inst_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        inst_valid <= 1'b0;
                        pc         <= redirect_pc;
                        cnt        <= 2'd0;
                        imem_addr  <= redirect_pc;
                        if (redirect_misaligned_c) begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc         <= pc + 32'd4;
                        imem_addr  <= pc + 32'd4;
                        cnt        <= 2'd0;
                        state      <= FETCH;
                    end
                end

                HALT:  ;
                FAULT: ;
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch sequence.
module tb_instr_fetch_ctrl;

    localparam int unsigned MEMSZ = 44;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;

    logic [7:0]  mem [0:MEMSZ-1];

    int n_checks;
    int n_fail;

    instr_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(MEMSZ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .halted        (halted),
        .fault         (fault),
        .fault_cause   (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational byte memory
    assign imem_rdata = (imem_addr < 32'(MEMSZ)) ? mem[imem_addr[5:0]] : 8'h00;

    function automatic logic [31:0] word_at(input int a);
        logic [5:0] i;
        i = 6'(a);
        return {mem[i + 6'd3], mem[i + 6'd2], mem[i + 6'd1], mem[i]};
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]     = w[7:0];
        mem[a + 1] = w[15:8];
        mem[a + 2] = w[23:16];
        mem[a + 3] = w[31:24];
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // partial fetch in progress before reset must be discarded
        do_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();
        n_checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b out=%h pc=%h addr=%h, required 0/0/0/0",
                     inst_valid, inst_out, inst_pc, imem_addr);
        end
        n_checks++;
        if (halted !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: halted=%b fault=%b cause=%b, required 0/0/00",
                     halted, fault, fault_cause);
        end
    endtask

    task automatic test_first_fetch();
        logic exp_v;
        do_reset();
        inst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_v = (k == 4);
            n_checks++;
            if (inst_valid !== exp_v) begin
                n_fail++;
                $display("FAIL first_latency cycle %0d: valid=%b, required %b", k, inst_valid, exp_v);
            end
        end
        n_checks++;
        if (inst_out !== 32'h0002A303 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL first_word: out=%h pc=%h, required 0002a303/00000000", inst_out, inst_pc);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_v = (k == 5);
            n_checks++;
            if (inst_valid !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_spacing cycle %0d: valid=%b, required %b", k, inst_valid, exp_v);
            end
        end
        n_checks++;
        if (inst_out !== 32'h00428293 || inst_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL second_word: out=%h pc=%h, required 00428293/00000004", inst_out, inst_pc);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (inst_valid !== 1'b1 || inst_out !== 32'h0002A303 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: valid=%b out=%h pc=%h addr=%h, required 1/0002a303/0/0",
                         k, inst_valid, inst_out, inst_pc, imem_addr);
            end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (imem_addr !== 32'(4 + k)) begin
                n_fail++;
                $display("FAIL stall_resume_addr %0d: addr=%h, required %h", k, imem_addr, 32'(4 + k));
            end
            @(negedge clk);
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL stall_resume_word: valid=%b pc=%h, required 1/00000004", inst_valid, inst_pc);
        end
    endtask

    task automatic test_redirect();
        logic exp_v;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (imem_addr !== 32'h2) begin
            n_fail++;
            $display("FAIL redirect_precnt: addr=%h, required 00000002", imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0C;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_addr !== 32'h0C || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_addr: addr=%h valid=%b, required 0000000c/0", imem_addr, inst_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_v = (k == 4);
            n_checks++;
            if (inst_valid !== exp_v) begin
                n_fail++;
                $display("FAIL redirect_latency cycle %0d: valid=%b, required %b", k, inst_valid, exp_v);
            end
        end
        n_checks++;
        if (inst_pc !== 32'h0C || inst_out !== 32'h00730C63) begin
            n_fail++;
            $display("FAIL redirect_word: out=%h pc=%h, required 00730c63/0000000c", inst_out, inst_pc);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0E;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || fault_cause !== 2'b01 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_fault: fault=%b cause=%b valid=%b, required 1/01/0",
                     fault, fault_cause, inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        inst_ready     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (fault !== 1'b1 || fault_cause !== 2'b01 || inst_valid !== 1'b0 || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_sticky %0d: fault=%b cause=%b valid=%b halted=%b, required 1/01/0/0",
                         k, fault, fault_cause, inst_valid, halted);
            end
        end
        do_reset();
        n_checks++;
        if (fault !== 1'b0 || fault_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_clear: fault=%b cause=%b, required 0/00", fault, fault_cause);
        end
    endtask

    task automatic test_range();
        int exp_pc;
        do_reset();
        inst_ready = 1'b1;
        exp_pc     = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (fault === 1'b1) break;
            if (inst_valid === 1'b1) begin
                n_checks++;
                if (inst_pc !== 32'(exp_pc) || inst_out !== word_at(exp_pc)) begin
                    n_fail++;
                    $display("FAIL range_seq: out=%h pc=%h, required %h/%h",
                             inst_out, inst_pc, word_at(exp_pc), 32'(exp_pc));
                end
                exp_pc += 4;
            end
        end
        inst_ready = 1'b0;
        n_checks++;
        if (exp_pc != 44 || fault !== 1'b1 || fault_cause !== 2'b10 || imem_addr !== 32'h2C || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL range_fault: words=%0d fault=%b cause=%b addr=%h valid=%b, required 11/1/10/0000002c/0",
                     exp_pc / 4, fault, fault_cause, imem_addr, inst_valid);
        end
    endtask

    task automatic test_halt();
        // halt mid-fetch parks the address on pc
        do_reset();
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_midfetch: halted=%b addr=%h valid=%b, required 1/0/0", halted, imem_addr, inst_valid);
        end
        // halt beats redirect while an instruction is waiting
        do_reset();
        repeat (4) @(negedge clk);
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        inst_ready     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h0 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_priority %0d: halted=%b valid=%b addr=%h fault=%b, required 1/0/0/0",
                         k, halted, inst_valid, imem_addr, fault);
            end
        end
        do_reset();
        n_checks++;
        if (halted !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_reset: halted=%b addr=%h, required 0/0", halted, imem_addr);
        end
        inst_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'h0002A303) begin
            n_fail++;
            $display("FAIL halt_restart: valid=%b pc=%h out=%h, required 1/0/0002a303",
                     inst_valid, inst_pc, inst_out);
        end
        inst_ready = 1'b0;
    endtask

    // Random ready/redirect traffic against a model that knows only the
    // architectural pc and how many cycles the current fetch has been running.
    task automatic test_random();
        int   pc_m;
        int   since;
        logic exp_v;
        logic rdy;
        logic rdr;
        int   tgt;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            pc_m  = 0;
            since = 0;
            for (int c = 0; c < 400; c++) begin
                exp_v = (since >= 4);
                n_checks++;
                if (inst_valid !== exp_v || fault !== 1'b0 ||
                    imem_addr !== 32'(exp_v ? pc_m : pc_m + since)) begin
                    n_fail++;
                    $display("FAIL rand_state r%0d c%0d: valid=%b fault=%b addr=%h, required %b/0/%h",
                             round, c, inst_valid, fault, imem_addr, exp_v,
                             32'(exp_v ? pc_m : pc_m + since));
                end
                if (exp_v) begin
                    n_checks++;
                    if (inst_pc !== 32'(pc_m) || inst_out !== word_at(pc_m)) begin
                        n_fail++;
                        $display("FAIL rand_word r%0d c%0d: out=%h pc=%h, required %h/%h",
                                 round, c, inst_out, inst_pc, word_at(pc_m), 32'(pc_m));
                    end
                end
                if (since == 0 && pc_m + 4 > int'(MEMSZ)) begin
                    inst_ready     = 1'b0;
                    redirect_valid = 1'b0;
                    @(negedge clk);
                    n_checks++;
                    if (fault !== 1'b1 || fault_cause !== 2'b10 || inst_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_range r%0d: fault=%b cause=%b valid=%b, required 1/10/0",
                                 round, fault, fault_cause, inst_valid);
                    end
                    break;
                end
                rdy = 1'($urandom % 2);
                rdr = ($urandom % 8) == 0;
                tgt = 4 * int'($urandom_range(0, 10));
                inst_ready     = rdy;
                redirect_valid = rdr;
                redirect_pc    = 32'(tgt);
                if (rdr) begin
                    pc_m  = tgt;
                    since = 0;
                end else if (exp_v && rdy) begin
                    pc_m  = pc_m + 4;
                    since = 0;
                end else if (!exp_v) begin
                    since++;
                end
                @(negedge clk);
            end
            inst_ready     = 1'b0;
            redirect_valid = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < int'(MEMSZ); i++) mem[i] = 8'($urandom);
        put_word(0,  32'h0002A303);
        put_word(4,  32'h00428293);
        put_word(12, 32'h00730C63);
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;

        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_misaligned();
        test_range();
        test_halt();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the byte-wide instruction memory. It owns the PC and issues four byte addresses per instruction. It assembles each little-endian 32-bit word and hands it to decode with a valid/ready handshake. It also accepts branch/jump redirects from execute, stops on halt (ecall), and flags misaligned or out-of-range fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
MEM_BYTES, 44, instruction memory size in bytes; valid fetch requires pc+4 <= MEM_BYTES.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
imem_addr  output  32  byte address to instruction memory
imem_rdata  input  8  byte at imem_addr, combinational, valid same cycle
inst_out  output  32  assembled instruction {b3,b2,b1,b0}
inst_pc  output  32  PC of inst_out
inst_valid  output  1  inst_out/inst_pc valid
inst_ready  input  1  decode accepts instruction
redirect_valid  input  1  load new PC (taken branch/jump)
redirect_pc  input  32  redirect target
halt  input  1  stop fetching (ecall retired)
halted  output  1  sticky halt indication
fault  output  1  sticky fetch fault
fault_cause  output  2  01 misaligned redirect, 10 out-of-range PC, 00 none

Behaviour:
- States: FETCH, VALID, HALT, FAULT. A byte counter cnt[1:0] is used in FETCH.
- Reset (sampled high at a rising edge):
  - state=FETCH, pc=RESET_PC, cnt=0.
  - inst_valid=0, inst_out=0, inst_pc=RESET_PC.
  - halted=0, fault=0, fault_cause=00.
  - Reset mid-fetch discards partial bytes.
- imem_addr:
  - FETCH: pc+cnt.
  - All other states: pc.
- FETCH, per cycle:
  - Capture imem_rdata into byte lane cnt; cnt<=cnt+1.
  - At cnt==3: inst_out<={lane3..lane0}, inst_pc<=pc, inst_valid<=1, cnt<=0, go VALID.
  - On FETCH entry: if pc+4 > MEM_BYTES, go FAULT with cause 10 instead of fetching. No bytes are captured.
- VALID:
  - inst_valid held with inst_out/inst_pc stable until inst_ready=1.
  - On inst_ready: inst_valid<=0, pc<=pc+4, go FETCH.
  - Latency: first inst_valid four cycles after reset deasserts. Back-to-back throughput is one instruction per 5 cycles with inst_ready held high.
- Redirect, accepted in FETCH or VALID:
  - pc<=redirect_pc, cnt<=0, inst_valid<=0 next cycle, go FETCH.
  - It overrides the same-cycle FETCH capture and the VALID handshake. An instruction presented with inst_ready=1 in that cycle counts as consumed; pc still comes from redirect_pc.
  - If redirect_pc[1:0]!=0: go FAULT, cause 01.
- halt (FETCH or VALID):
  - Go HALT, halted<=1, inst_valid<=0.
  - halt has priority over redirect_valid in the same cycle.
- HALT: terminal until reset.
  - redirect_valid, inst_ready and halt are ignored; imem_addr holds pc.
- FAULT: terminal until reset.
  - fault=1, fault_cause holds the first cause, inst_valid=0, imem_addr holds the offending pc.
  - All inputs except reset are ignored.
- Priority within a cycle: reset > halt > redirect > inst_ready/FETCH progress.
- Arithmetic: pc is 32-bit and wraps modulo 2^32. A wrapped value fails the range check and goes FAULT (cause 10).

Test Plan:
1. Memory bytes 0..3 = 03,a3,02,00; reset 1 cycle; inst_ready=1 -> inst_valid rises 4 cycles after reset release with inst_out=0x0002A303, inst_pc=0. Next instruction at inst_pc=4, inst_out=0x00428293, 5 cycles later.
2. inst_ready=0 for 10 cycles while valid -> inst_out/inst_pc stable, imem_addr held, no pc advance. Raise ready -> following fetch addresses 4,5,6,7.
3. redirect_valid with redirect_pc=0x0C during cnt=2 of a FETCH -> partial word discarded. Next inst_valid shows inst_pc=0x0C, inst_out=0x00730C63.
4. redirect_pc=0x0E -> fault=1, fault_cause=01 next cycle, inst_valid stays 0. Further redirects are ignored until reset, which clears fault.
5. Run sequentially to pc=0x2C with MEM_BYTES=44 -> fault=1, fault_cause=10, imem_addr=0x2C, no inst_valid.
6. halt and redirect_valid asserted in the same cycle -> halted=1, pc unchanged, inst_valid=0. Then reset mid-HALT -> halted=0, fetch restarts at RESET_PC.
